// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the iterative divider: default
//               operand width, controller state type and the quotient value
//               reported on a divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default operand / result width.
    localparam int c_data_w = 32;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient reported for a zero divisor. Callers slice it to their width,
    // so it is wide enough for any practical DATA_W.
    localparam logic [63:0] c_dbz_quotient = '1;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_sub_stage.sv
`default_nettype none
// ============================================================================
// Module      : div_sub_stage
// Description : Combinational trial subtractor for one restoring-division
//               step. Computes minuend - subtrahend and reports whether the
//               result is non-negative (no borrow).
// Ports       : minuend    [WIDTH-1:0] in  - shifted partial remainder
//               subtrahend [WIDTH-1:0] in  - zero-extended divisor
//               difference [WIDTH-1:0] out - minuend - subtrahend (modulo)
//               non_neg                out - 1 when minuend >= subtrahend
// Revision    : 1.0 - initial release
// ============================================================================
module div_sub_stage
    import div_pkg::*;
#(
    parameter int WIDTH = c_data_w + 1
) (
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic [WIDTH-1:0] difference,
    output logic             non_neg
);

    // One extra bit carries the borrow out of the subtraction.
    logic [WIDTH:0] w_wide;

    assign w_wide     = {1'b0, minuend} - {1'b0, subtrahend};
    assign difference = w_wide[WIDTH-1:0];
    assign non_neg    = ~w_wide[WIDTH];

endmodule : div_sub_stage
`default_nettype wire

// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
// Module      : iter_divider
// Description : Radix-2 restoring divider, one quotient bit per clock.
//               A division takes DATA_W CALC cycles followed by a one-cycle
//               DONE pulse; a zero divisor goes straight to DONE with
//               quotient all ones, remainder = dividend and div_by_zero set.
//               Results are held until the next accepted start.
// Config      : SIGNED_DIV_EN - adds input signed_op; when set, operands are
//               two's complement, magnitudes are divided and the signs are
//               applied on the edge entering DONE.
// Ports       : clk, rst_n (sync, active low), start, dividend, divisor,
//               [signed_op], busy, done, quotient, remainder, div_by_zero
// Revision    : 1.0 - initial release
// ============================================================================
module iter_divider
    import div_pkg::*;
#(
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic              signed_op,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    localparam int c_cnt_w = $clog2(DATA_W + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_div;

    logic                w_accept;
    logic                w_div_zero;
    logic                w_last;
    logic [DATA_W:0]     w_trial_in;
    logic [DATA_W:0]     w_diff;
    logic                w_non_neg;
    logic [DATA_W-1:0]   w_rem_next;
    logic [DATA_W-1:0]   w_quo_next;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W-1:0]   w_q_fin;
    logic [DATA_W-1:0]   w_r_fin;
    logic                w_unused_bits;

    assign w_div_zero = (divisor == '0);
    assign w_last     = (r_cnt == c_cnt_w'(1));

    // ------------------------------------------------------------------
    // Restoring step: shift {rem,quo} left, try rem - divisor.
    // ------------------------------------------------------------------
    assign w_trial_in = {r_rem, r_quo[DATA_W-1]};

    div_sub_stage #(
        .WIDTH (DATA_W + 1)
    ) u_sub (
        .minuend    (w_trial_in),
        .subtrahend ({1'b0, r_div}),
        .difference (w_diff),
        .non_neg    (w_non_neg)
    );

    // Partial remainder stays below the divisor, so the top bit of both the
    // restored and the subtracted value is always zero.
    assign w_rem_next    = w_non_neg ? w_diff[DATA_W-1:0] : w_trial_in[DATA_W-1:0];
    assign w_quo_next    = {r_quo[DATA_W-2:0], w_non_neg};
    assign w_unused_bits = w_diff[DATA_W] ^ w_trial_in[DATA_W];

    // ------------------------------------------------------------------
    // Operand magnitudes and final sign correction.
    // ------------------------------------------------------------------
`ifdef SIGNED_DIV_EN
    logic w_a_neg;
    logic w_b_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_a_neg = signed_op & dividend[DATA_W-1];
    assign w_b_neg = signed_op & divisor[DATA_W-1];
    assign w_a_mag = w_a_neg ? -dividend : dividend;
    assign w_b_mag = w_b_neg ? -divisor  : divisor;
    // Most-negative / -1 wraps back to most-negative here, as intended.
    assign w_q_fin = r_neg_q ? -w_quo_next : w_quo_next;
    assign w_r_fin = r_neg_r ? -w_rem_next : w_rem_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end
    end
`else
    assign w_a_mag = dividend;
    assign w_b_mag = divisor;
    assign w_q_fin = w_quo_next;
    assign w_r_fin = w_rem_next;
`endif

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A start during the done cycle launches the next division
                // with no idle gap.
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_div_zero ? DONE : CALC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= c_cnt_w'(DATA_W);
            r_rem <= '0;
            r_quo <= w_a_mag;
            r_div <= w_b_mag;
            if (w_div_zero) begin
                quotient    <= c_dbz_quotient[DATA_W-1:0];
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            if (w_last) begin
                quotient    <= w_q_fin;
                remainder   <= w_r_fin;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule : iter_divider
`default_nettype wire
